rom_read_ctrl: RTL and testbench

- Bus-side sequencer that sits directly upstream of the 16K x 8 program ROM.
- Drives the ROM's address and active-low enable, samples its data bus, and returns the byte to a requesting master through a req/ack handshake.
- Also contains a power-on self-test walker. It reads the whole ROM and reports an 8-bit additive checksum for each 2 KB bank, matching the arcade's per-chip ROM test.

---
 rtl/rom_read_ctrl_pkg.sv | 8 +
 rtl/rom_read_ctrl_if.sv | 14 +
 rtl/rom_read_ctrl_bank_checksum.sv | 45 ++++
 rtl/rom_read_ctrl.sv | 116 +++++++++++
 tb/tb_rom_read_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_read_ctrl_pkg.sv
// rom_ctrl_pkg: sequencer state type and ROM geometry shared by the ROM read controller files
package rom_ctrl_pkg;
    localparam int ROM_ADDR_W = 14;
    localparam int ROM_DATA_W = 8;
    localparam int BANK_W     = 11;
    localparam int BANK_CNT   = 1 << (ROM_ADDR_W - BANK_W);
    typedef enum logic [2:0] {IDLE, RD_ASSERT, RD_TURN, T_RUN, T_TURN} state_t;
endpackage

// File: rtl/rom_read_ctrl_if.sv
// rom_read_ctrl_if: master read handshake between a bus master and the ROM read controller
// req/addr: master -> controller; ack/rdata/busy: controller -> master
interface rom_read_ctrl_if #(
    parameter int ADDR_W = rom_ctrl_pkg::ROM_ADDR_W,
    parameter int DATA_W = rom_ctrl_pkg::ROM_DATA_W
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    modport master (output req, addr, input ack, rdata, busy);
    modport slave  (input req, addr, output ack, rdata, busy);
endinterface

// File: rtl/rom_read_ctrl_bank_checksum.sv
// bank_checksum: per-bank additive checksum of the self-test byte stream
// step: one byte consumed at addr/data; bank_valid/bank_idx/bank_sum: result of the bank just closed
module bank_checksum #(
    parameter int ADDR_W = rom_ctrl_pkg::ROM_ADDR_W,
    parameter int DATA_W = rom_ctrl_pkg::ROM_DATA_W,
    parameter int BANK_W = rom_ctrl_pkg::BANK_W
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     step,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        data,
    output logic                     bank_valid,
    output logic [ADDR_W-BANK_W-1:0] bank_idx,
    output logic [DATA_W-1:0]        bank_sum
);
    import rom_ctrl_pkg::*;
    logic [DATA_W-1:0]        acc_q, acc_d, sum_q, sum_d;
    logic [ADDR_W-BANK_W-1:0] idx_q, idx_d;
    logic                     valid_q, valid_d, bank_end;
    // the last byte of a bank closes it; the accumulator restarts for the next bank
    always_comb begin
        bank_end = step && (&addr[BANK_W-1:0]);
        acc_d    = step ? (bank_end ? '0 : acc_q + data) : acc_q;
        sum_d    = bank_end ? acc_q + data : sum_q;
        idx_d    = bank_end ? addr[ADDR_W-1:BANK_W] : idx_q;
        valid_d  = bank_end;
    end
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            acc_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end
    assign bank_valid = valid_q;
    assign bank_idx   = idx_q;
    assign bank_sum   = sum_q;
endmodule

// File: rtl/rom_read_ctrl.sv
// rom_read_ctrl: ROM read sequencer serving master reads and a whole-ROM per-bank checksum self-test
// bus: req/addr in, ack/rdata/busy out; test_start in; bank_valid/bank_idx/bank_sum/test_done out;
// rom_addr/rom_ena_l out to the ROM, rom_data in from it
module rom_read_ctrl #(
    parameter int ADDR_W   = rom_ctrl_pkg::ROM_ADDR_W,
    parameter int DATA_W   = rom_ctrl_pkg::ROM_DATA_W,
    parameter int WAIT_CYC = 1,
    parameter int BANK_W   = rom_ctrl_pkg::BANK_W
) (
    input  logic                     clk,
    input  logic                     rst_l,
    rom_read_ctrl_if.slave           bus,
    input  logic                     test_start,
    output logic                     bank_valid,
    output logic [ADDR_W-BANK_W-1:0] bank_idx,
    output logic [DATA_W-1:0]        bank_sum,
    output logic                     test_done,
    output logic [ADDR_W-1:0]        rom_addr,
    output logic                     rom_ena_l,
    input  logic [DATA_W-1:0]        rom_data
);
    import rom_ctrl_pkg::*;
    state_t            state_q, state_d;
    logic [2:0]        wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rom_ena_l_q, rom_ena_l_d, ack_q, ack_d, busy_q, busy_d, test_done_q, test_done_d;
    logic              win_end, step;
    assign win_end = wcnt_q == 3'(WAIT_CYC - 1);
    always_comb begin
        state_d     = state_q;
        wcnt_d      = '0;
        rom_addr_d  = rom_addr_q;
        rom_ena_l_d = rom_ena_l_q;
        rdata_d     = rdata_q;
        ack_d       = 1'b0;
        test_done_d = 1'b0;
        step        = 1'b0;
        case (state_q)
            IDLE: begin
                // self-test wins; a concurrent req stays pending until the test ends
                if (test_start) begin
                    state_d     = T_RUN;
                    rom_addr_d  = '0;
                    rom_ena_l_d = 1'b0;
                end else if (bus.req) begin
                    state_d     = RD_ASSERT;
                    rom_addr_d  = bus.addr;
                    rom_ena_l_d = 1'b0;
                end
            end
            RD_ASSERT: begin
                wcnt_d = win_end ? '0 : wcnt_q + 3'd1;
                if (win_end) begin
                    state_d     = RD_TURN;
                    rdata_d     = rom_data;
                    ack_d       = 1'b1;
                    rom_ena_l_d = 1'b1;
                end
            end
            RD_TURN: state_d = IDLE;
            T_RUN: begin
                // enable stays low across the whole sweep; the last address stops without wrapping
                wcnt_d = win_end ? '0 : wcnt_q + 3'd1;
                step   = win_end;
                if (win_end && (&rom_addr_q)) begin
                    state_d     = T_TURN;
                    test_done_d = 1'b1;
                    rom_ena_l_d = 1'b1;
                end else if (win_end) begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                end
            end
            T_TURN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            rom_addr_q  <= '0;
            rom_ena_l_q <= 1'b1;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            test_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rom_addr_q  <= rom_addr_d;
            rom_ena_l_q <= rom_ena_l_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            test_done_q <= test_done_d;
        end
    end
    bank_checksum #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BANK_W(BANK_W)) u_sum (
        .clk(clk),
        .rst_l(rst_l),
        .step(step),
        .addr(rom_addr_q),
        .data(rom_data),
        .bank_valid(bank_valid),
        .bank_idx(bank_idx),
        .bank_sum(bank_sum)
    );
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign rom_addr  = rom_addr_q;
    assign rom_ena_l = rom_ena_l_q;
    assign test_done = test_done_q;
endmodule

// File: tb/tb_rom_read_ctrl.sv
// tb_rom_read_ctrl: two controllers (WAIT_CYC 1 and 3) checked every cycle against an elapsed-time model
module tb_rom_read_ctrl;
    typedef struct {
        int         op;
        int         t;
        logic [13:0] a;
        logic [7:0] rd;
        logic [7:0] bs;
        logic [2:0] bi;
    } mdl_t;
    typedef struct {
        int          c;
        int          k;
        int          f;
        logic [31:0] v;
    } lit_t;

    logic        clk = 0;
    logic        rst_l = 0;
    logic        req_i [2];
    logic [13:0] addr_i [2];
    logic        ts_i [2];
    logic        ack_o [2], busy_o [2], bv [2], td [2], ena [2];
    logic [7:0]  rdata_o [2], bs [2], rdat [2];
    logic [2:0]  bi [2];
    logic [13:0] ra [2];
    logic [7:0]  rom [16384];
    mdl_t        m [2];
    lit_t        lits [$];
    int          cyc = 0, errors = 0, checks = 0, tmo = 0, tmo_seen = 0;
    string       nm [9] = '{"ack", "rdata", "rom_ena_l", "bank_valid", "bank_idx", "bank_sum", "test_done", "busy", "rom_addr"};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rom_read_ctrl_if bus1 ();
    rom_read_ctrl_if bus3 ();
    assign bus1.req  = req_i[0];
    assign bus1.addr = addr_i[0];
    assign bus3.req  = req_i[1];
    assign bus3.addr = addr_i[1];
    assign ack_o[0] = bus1.ack;
    assign ack_o[1] = bus3.ack;
    assign rdata_o[0] = bus1.rdata;
    assign rdata_o[1] = bus3.rdata;
    assign busy_o[0] = bus1.busy;
    assign busy_o[1] = bus3.busy;
    // a released bus reads as junk so any sample taken while it floats shows up
    assign rdat[0] = ena[0] ? 8'hC3 : rom[ra[0]];
    assign rdat[1] = ena[1] ? 8'hC3 : rom[ra[1]];

    rom_read_ctrl #(.WAIT_CYC(1)) u1 (
        .clk(clk), .rst_l(rst_l), .bus(bus1.slave), .test_start(ts_i[0]),
        .bank_valid(bv[0]), .bank_idx(bi[0]), .bank_sum(bs[0]), .test_done(td[0]),
        .rom_addr(ra[0]), .rom_ena_l(ena[0]), .rom_data(rdat[0])
    );
    rom_read_ctrl #(.WAIT_CYC(3)) u3 (
        .clk(clk), .rst_l(rst_l), .bus(bus3.slave), .test_start(ts_i[1]),
        .bank_valid(bv[1]), .bank_idx(bi[1]), .bank_sum(bs[1]), .test_done(td[1]),
        .rom_addr(ra[1]), .rom_ena_l(ena[1]), .rom_data(rdat[1])
    );

    function automatic int wof(int k);
        return k == 1 ? 3 : 1;
    endfunction

    function automatic logic [7:0] bsum(int b);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 2048; i++) s += rom[b * 2048 + i];
        return s;
    endfunction

    // model: op 0 idle, 1 read, 2 self-test; t counts cycles since the accepting edge
    function automatic mdl_t nxt(mdl_t s, int k);
        mdl_t n = s;
        int w = wof(k);
        int tot = 16384 * w;
        int bw = 2048 * w;
        if (s.op == 0) begin
            if (ts_i[k]) begin
                n.op = 2; n.t = 1; n.a = 14'h0;
            end else if (req_i[k]) begin
                n.op = 1; n.t = 1; n.a = addr_i[k];
            end
        end else if (s.op == 1) begin
            if (s.t == w + 1) n.op = 0;
            else begin
                n.t = s.t + 1;
                if (n.t == w + 1) n.rd = rom[s.a];
            end
        end else begin
            if (s.t == tot + 1) n.op = 0;
            else begin
                n.t = s.t + 1;
                n.a = (n.t <= tot) ? 14'((n.t - 1) / w) : 14'h3FFF;
                if ((n.t - 1) % bw == 0) begin
                    n.bi = 3'((n.t - 1) / bw - 1);
                    n.bs = bsum((n.t - 1) / bw - 1);
                end
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] exp_out(mdl_t s, int k, int f);
        int w = wof(k);
        int tot = 16384 * w;
        int bw = 2048 * w;
        case (f)
            0: return 32'(s.op == 1 && s.t == w + 1);
            1: return 32'(s.rd);
            2: return 32'(!((s.op == 1 && s.t <= w) || (s.op == 2 && s.t <= tot)));
            3: return 32'(s.op == 2 && s.t > 1 && (s.t - 1) % bw == 0);
            4: return 32'(s.bi);
            5: return 32'(s.bs);
            6: return 32'(s.op == 2 && s.t == tot + 1);
            7: return 32'(s.op != 0);
            default: return 32'(s.a);
        endcase
    endfunction

    function automatic logic [31:0] dut(int k, int f);
        case (f)
            0: return 32'(ack_o[k]);
            1: return 32'(rdata_o[k]);
            2: return 32'(ena[k]);
            3: return 32'(bv[k]);
            4: return 32'(bi[k]);
            5: return 32'(bs[k]);
            6: return 32'(td[k]);
            7: return 32'(busy_o[k]);
            default: return 32'(ra[k]);
        endcase
    endfunction

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) for (int k = 0; k < 2; k++) m[k] <= '{default: 0};
        else for (int k = 0; k < 2; k++) m[k] <= nxt(m[k], k);
    end

    task automatic chk(string n, int w, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s (WAIT_CYC=%0d) cycle %0d: got %0h expected %0h", n, w, cyc, a, e);
        end
    endtask

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            for (int f = 0; f < 9; f++) chk(nm[f], wof(k), dut(k, f), exp_out(m[k], k, f));
        foreach (lits[i])
            if (lits[i].c == cyc) chk({"pinned_", nm[lits[i].f]}, wof(lits[i].k), dut(lits[i].k, lits[i].f), lits[i].v);
        chk("wait_timeout", 0, 32'(tmo), 32'(tmo_seen));
        tmo_seen = tmo;
    end

    task automatic lit(int c, int k, int f, logic [31:0] v);
        lits.push_back('{c, k, f, v});
    endtask

    task automatic wait_ack(int k, int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ack_o[k]) return;
        end
        tmo++;
    endtask

    task automatic wait_idle(int k, int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (!busy_o[k]) return;
        end
        tmo++;
    endtask

    initial begin
        int c, r;
        req_i = '{1'b0, 1'b0};
        ts_i = '{1'b0, 1'b0};
        addr_i = '{14'h0, 14'h0};
        for (int i = 0; i < 16384; i++) rom[i] = 8'($urandom);
        repeat (2) @(negedge clk);
        for (int f = 0; f < 9; f++) lit(cyc + 1, 0, f, 32'(f == 2));
        @(negedge clk);
        rst_l = 1;
        @(negedge clk);
        // single read, WAIT_CYC=1
        rom[14'h1234] = 8'hA5;
        c = cyc;
        req_i[0] = 1; addr_i[0] = 14'h1234;
        lit(c + 1, 0, 2, 0); lit(c + 1, 0, 0, 0);
        lit(c + 2, 0, 0, 1); lit(c + 2, 0, 1, 8'hA5); lit(c + 2, 0, 2, 1);
        wait_ack(0, 20);
        req_i[0] = 0;
        // back-to-back reads, WAIT_CYC=3, req held throughout
        rom[14'h0000] = 8'h11; rom[14'h3FFF] = 8'hEE;
        @(negedge clk);
        c = cyc;
        req_i[1] = 1; addr_i[1] = 14'h0000;
        for (int i = 1; i <= 3; i++) lit(c + i, 1, 2, 0);
        lit(c + 4, 1, 0, 1); lit(c + 4, 1, 1, 8'h11); lit(c + 4, 1, 2, 1);
        lit(c + 9, 1, 0, 1); lit(c + 9, 1, 1, 8'hEE); lit(c + 9, 1, 2, 1); lit(c + 8, 1, 0, 0);
        wait_ack(1, 20);
        addr_i[1] = 14'h3FFF;
        wait_ack(1, 20);
        req_i[1] = 0;
        // self-test on a known ROM image
        for (int i = 0; i < 16384; i++) rom[i] = 8'h01;
        rom[14'h0805] = 8'h10;
        @(negedge clk);
        c = cyc;
        ts_i[0] = 1;
        lit(c + 2048, 0, 3, 0);
        lit(c + 2049, 0, 3, 1); lit(c + 2049, 0, 4, 0); lit(c + 2049, 0, 5, 8'h00);
        lit(c + 4097, 0, 3, 1); lit(c + 4097, 0, 4, 1); lit(c + 4097, 0, 5, 8'h0F);
        lit(c + 16384, 0, 6, 0);
        lit(c + 16385, 0, 6, 1); lit(c + 16385, 0, 3, 1); lit(c + 16385, 0, 4, 7); lit(c + 16385, 0, 5, 8'h00);
        @(negedge clk);
        ts_i[0] = 0;
        wait_idle(0, 20000);
        // req coincident with test_start waits for the test; a mid-test test_start is ignored
        rom[14'h0100] = 8'h5C;
        @(negedge clk);
        c = cyc;
        ts_i[0] = 1; req_i[0] = 1; addr_i[0] = 14'h0100;
        lit(c + 16385, 0, 6, 1); lit(c + 16386, 0, 7, 0); lit(c + 16387, 0, 0, 0);
        lit(c + 16388, 0, 0, 1); lit(c + 16388, 0, 1, 8'h5C);
        @(negedge clk);
        ts_i[0] = 0;
        while (cyc < c + 5000) @(negedge clk);
        ts_i[0] = 1;
        @(negedge clk);
        ts_i[0] = 0;
        wait_ack(0, 20000);
        req_i[0] = 0;
        // reset in the middle of a test, then a full clean run
        for (int i = 0; i < 16384; i++) rom[i] = 8'($urandom);
        @(negedge clk);
        c = cyc;
        ts_i[0] = 1;
        lit(c + 2304, 0, 8, 14'h08FF);
        @(negedge clk);
        ts_i[0] = 0;
        while (cyc < c + 2304) @(negedge clk);
        @(posedge clk);
        #2;
        rst_l = 0;
        r = cyc;
        for (int f = 0; f < 9; f++) lit(r, 0, f, 32'(f == 2));
        repeat (2) @(negedge clk);
        rst_l = 1;
        @(negedge clk);
        c = cyc;
        ts_i[0] = 1;
        lit(c + 16385, 0, 6, 1); lit(c + 16385, 0, 4, 7);
        @(negedge clk);
        ts_i[0] = 0;
        wait_idle(0, 20000);
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
